// File: rtl/seg_display_scanner_if.sv
// Bundle of the signals between the CPU top and the seven-segment scanner.
// master: CPU-side producer of the display word, halt flag and strobe.
// slave : scanner, which consumes the word and drives the board pins.
interface seg_display_scanner_if;
    logic [31:0] value;
    logic        value_vld;
    logic        halt;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;

    modport master (
        output value,
        output value_vld,
        output halt,
        input  an_n,
        input  seg_n
    );

    modport slave (
        input  value,
        input  value_vld,
        input  halt,
        output an_n,
        output seg_n
    );
endinterface

// File: rtl/seg_display_scanner.sv
// Eight-digit common-anode seven-segment scanner.
// It latches the CPU display word into a shadow register. It time-multiplexes
// the digits with a guard interval at the start of each slot, during which all
// anodes are off. Digit 0's decimal point shows the live halt flag.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits
// above digit 0.
module seg_display_scanner #(
    parameter int unsigned ScanBits    = 17,
    parameter int unsigned GuardCycles = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_scanner_if.slave  bus
);

    localparam logic [ScanBits-1:0] GuardLim = ScanBits'(GuardCycles);

    logic [ScanBits-1:0] cnt;
    logic [2:0]          idx;
    logic [31:0]         shadow;
    logic [7:0]          an_n_q;
    logic [7:0]          seg_n_q;

    logic [7:0]          an_d;
    logic [7:0]          seg_d;
    logic [3:0]          nib;
    logic                blank;

    // Hex to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh counter and digit index; idx advances when cnt wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Shadow copy of the display word, loaded only on the capture strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (bus.value_vld) begin
            shadow <= bus.value;
        end
    end

    // Next anode and segment pattern from the pre-edge scan position and shadow.
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        nib   = shadow[{idx, 2'b00} +: 4];
        blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank = (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
`endif
        if (!(cnt < GuardLim) && !blank) begin
            an_d  = ~(8'h01 << idx);
            seg_d = {~((idx == 3'd0) && bus.halt), hex_to_seg(nib)};
        end
    end

    // Registered pin drivers give one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n_q  <= '1;
            seg_n_q <= '1;
        end else begin
            an_n_q  <= an_d;
            seg_n_q <= seg_d;
        end
    end

    assign bus.an_n  = an_n_q;
    assign bus.seg_n = seg_n_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner with ScanBits=2 and GuardCycles=1,
// which gives a slot of 4 cycles and a frame of 32 cycles. The driver pushes
// one expected pin pattern for each clock edge. The monitor pops that entry
// and compares it one time step after the edge.
module tb_seg_display_scanner;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seg_display_scanner_if bus ();

    seg_display_scanner #(
        .ScanBits    (2),
        .GuardCycles (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Bench-side view of the scan position and shadow before each edge.
    int unsigned m_cnt;
    logic [2:0]  m_idx;
    logic [31:0] m_sh;

    // Full seg_n values with the decimal point off, taken from the decode table.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    function automatic exp_t expect_pins(input int unsigned c, input logic [2:0] i,
                                         input logic [31:0] sh, input logic h);
        exp_t e;
        logic bl;
        logic [31:0] up;
        e.an  = 8'hFF;
        e.seg = 8'hFF;
        bl    = 1'b0;
        up    = sh >> (4 * int'(i));
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bl = (i != 3'd0) && (up == 32'd0);
`endif
        if (c >= 1 && !bl) begin
            e.an  = ~(8'h01 << i);
            e.seg = hex7(up[3:0]);
            if (i == 3'd0 && h) e.seg[7] = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, queue the pattern expected after the next edge.
    task automatic step(input logic r, input logic [31:0] v, input logic vl, input logic h);
        exp_t e;
        rst           = r;
        bus.value     = v;
        bus.value_vld = vl;
        bus.halt      = h;
        if (r) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
            m_cnt = 0;
            m_idx = 3'd0;
            m_sh  = 32'd0;
        end else begin
            e = expect_pins(m_cnt, m_idx, m_sh, h);
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = m_idx + 3'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (vl) m_sh = v;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input logic [31:0] v, input logic h);
        for (int unsigned k = 0; k < n; k++) step(1'b0, v, 1'b0, h);
    endtask

    // Monitor: one output pattern is presented per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.an_n !== e.an || bus.seg_n !== e.seg) begin
                    n_bad++;
                    $display("FAIL pins vec %0d: an_n=%h seg_n=%h, expected an_n=%h seg_n=%h",
                             n_vec, bus.an_n, bus.seg_n, e.an, e.seg);
                end
            end
        end
    end

    initial begin
        // Reset is held with a capture strobe active; the shadow must stay 0.
        for (int unsigned k = 0; k < 3; k++) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle(36, 32'h0, 1'b0);

        // Scan and decode of 0x12345678 over two frames.
        step(1'b0, 32'h1234_5678, 1'b1, 1'b0);
        idle(64, 32'h1234_5678, 1'b0);

        // A new word without the strobe has no effect. A strobe in mid-slot does.
        idle(66, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle(40, 32'h0, 1'b0);

        // Live halt drives digit 0's decimal point.
        step(1'b0, 32'h0000_0007, 1'b1, 1'b1);
        idle(33, 32'h0, 1'b1);
        idle(16, 32'h0, 1'b0);

        // Leading-zero pattern, plus an all-zero word.
        step(1'b0, 32'h0000_00A0, 1'b1, 1'b0);
        idle(33, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        idle(33, 32'h0, 1'b0);

        // Capture on the same edge as the idx 7 -> 0 wrap.
        for (int k = 0; k < 40 && !(m_cnt == 3 && m_idx == 3'd7); k++) idle(1, 32'h0, 1'b0);
        step(1'b0, 32'hCAFE_0009, 1'b1, 1'b0);
        idle(12, 32'h0, 1'b0);

        // Reset in mid-scan restarts at digit 0 at the start of its slot.
        for (int k = 0; k < 40 && !(m_cnt == 2 && m_idx == 3'd3); k++) idle(1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        idle(12, 32'h0, 1'b1);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
